// File: rtl/teller_dispatch_ctrl.sv
// Round-robin dispatcher that calls the head customer to a free teller and tracks which desks are busy.
// Optional feature macro: NOSHOW_TIMEOUT_EN (unanswered calls time out and the no-show leaves the queue).
module teller_dispatch_ctrl #(
    parameter int N_TELLERS = 3,
    parameter int PCOUNT_W  = 3,
`ifdef NOSHOW_TIMEOUT_EN
    parameter int CALL_TMO  = 64,
`endif
    parameter int SVC_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PCOUNT_W-1:0]  p_count,
    input  logic [N_TELLERS-1:0] teller_open,
    input  logic [N_TELLERS-1:0] teller_done,
    input  logic                 call_ack,
    output logic                 call_valid,
    output logic [1:0]           call_teller,
    output logic                 dequeue,
    output logic [N_TELLERS-1:0] busy,
    output logic [1:0]           t_count,
    output logic [SVC_CNT_W-1:0] served_cnt
);

    typedef enum logic [1:0] {IDLE, CALL, DEQ, SETTLE} state_t;

    state_t                 state;
    logic [1:0]             rr_ptr;
    logic [1:0]             rr_next;
    logic [3:0]             open_ext;
    logic [3:0]             elig_ext;
    logic [2:0]             cand;
    logic [2:0]             open_cnt;
    logic                   grant_found;
    logic [1:0]             grant_idx;
    logic                   abort;
    logic [N_TELLERS-1:0]   busy_clr;
    logic [N_TELLERS-1:0]   set_mask;

`ifdef NOSHOW_TIMEOUT_EN
    localparam int TMO_W = $clog2(CALL_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CALL_TMO - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    always_comb begin
        // Padding to four entries keeps the 2-bit desk index in range for any legal N_TELLERS.
        open_ext = '0;
        open_ext[N_TELLERS-1:0] = teller_open;
        elig_ext = '0;
        elig_ext[N_TELLERS-1:0] = teller_open & ~busy;
        busy_clr = busy & ~teller_done;
        set_mask = '0;
        open_cnt = '0;
        for (int unsigned i = 0; i < N_TELLERS; i++) begin
            set_mask[i] = (call_teller == 2'(i));
            open_cnt    = open_cnt + 3'(teller_open[i]);
        end
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < N_TELLERS; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'(N_TELLERS))
                cand = cand - 3'(N_TELLERS);
            if (!grant_found && elig_ext[cand[1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[1:0];
            end
        end
        abort   = ~open_ext[call_teller] | (p_count == '0);
        rr_next = (call_teller == 2'(N_TELLERS - 1)) ? 2'd0 : call_teller + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            call_valid  <= 1'b0;
            call_teller <= '0;
            dequeue     <= 1'b0;
            busy        <= '0;
            t_count     <= '0;
            served_cnt  <= '0;
            rr_ptr      <= '0;
`ifdef NOSHOW_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            t_count <= (open_cnt > 3'd3) ? 2'd3 : open_cnt[1:0];
            dequeue <= 1'b0;
            busy    <= busy_clr;
            case (state)
                IDLE: begin
                    if (p_count != '0 && grant_found) begin
                        call_teller <= grant_idx;
                        call_valid  <= 1'b1;
                        state       <= CALL;
`ifdef NOSHOW_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                CALL: begin
                    // Abort outranks a same-cycle ack; a set of busy outranks a same-cycle done.
                    if (abort) begin
                        call_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (call_ack) begin
                        call_valid <= 1'b0;
                        dequeue    <= 1'b1;
                        busy       <= busy_clr | set_mask;
                        served_cnt <= served_cnt + SVC_CNT_W'(1);
                        rr_ptr     <= rr_next;
                        state      <= DEQ;
                    end
`ifdef NOSHOW_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        call_valid <= 1'b0;
                        dequeue    <= 1'b1;
                        rr_ptr     <= rr_next;
                        state      <= SETTLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                DEQ:     state <= SETTLE;
                SETTLE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
